// File: rtl/uart_rx_deframer.sv
`timescale 1ns/1ps
// uart_rx_deframer: oversampling UART receiver (start, 8 data LSB first, optional parity,
// stop) feeding a one-entry valid/ready holding register with frame/parity/overrun status.
module uart_rx_deframer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic       CLK_50_MAX10,
  input  logic       CPU_RESET,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_BUSY,
  output logic       RX_FRAME_ERR,
  output logic       RX_PARITY_ERR,
  output logic       RX_OVERRUN,
  input  logic       RX_ERR_CLR
);

  localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B      = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C      = SW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2, w_rx;
  logic [DW-1:0]   r_div;
  logic            w_tick;
  logic [SW-1:0]   r_s;
  logic [1:0]      r_smp;
  logic            w_maj, w_decide;
  logic [7:0]      r_shift, r_byte;
  logic [2:0]      r_bit;
  logic            r_par_bad;
  logic            w_deliver, w_ferr, w_perr;
  logic            r_deliver, r_busy, r_ferr, r_perr;
  logic [7:0]      r_data;
  logic            r_valid, r_ovr;

  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    logic odd;
    odd = (PARITY == 2) ? 1'b1 : 1'b0;
    return (^d) ^ p ^ odd;
  endfunction

  assign w_rx     = r_sync2;
  assign w_tick   = (r_div == DIV_LAST);
  assign w_decide = w_tick && (r_s == S_C);
  assign w_maj    = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx) | (r_smp[1] & w_rx);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Sample phase restarts on every start detection so the 3-sample window sits mid-bit.
  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_s <= '0;
    end else if (r_state == ST_IDLE) begin
      r_s <= '0;
    end else if (w_tick) begin
      r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
    end else begin
      r_s <= r_s;
    end
  end

  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_smp     <= 2'b00;
      r_shift   <= 8'h00;
      r_bit     <= 3'd0;
      r_par_bad <= 1'b0;
    end else begin
      if (w_tick && (r_s == S_A)) r_smp[0] <= w_rx;
      if (w_tick && (r_s == S_B)) r_smp[1] <= w_rx;
      if (r_state == ST_IDLE) begin
        r_bit     <= 3'd0;
        r_par_bad <= 1'b0;
      end else if (w_decide && (r_state == ST_DATA)) begin
        r_shift <= {w_maj, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end else if (w_decide && (r_state == ST_PARITY)) begin
        r_par_bad <= parity_bad(r_shift, w_maj);
      end
    end
  end

  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx) w_state_nxt = ST_START;
        else       w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_decide) w_state_nxt = w_maj ? ST_IDLE : ST_DATA;
        else          w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_decide && (r_bit == 3'd7)) w_state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
        else                             w_state_nxt = ST_DATA;
      end
      ST_PARITY: begin
        if (w_decide) w_state_nxt = ST_STOP;
        else          w_state_nxt = ST_PARITY;
      end
      ST_STOP: begin
        if (w_decide && !w_maj) begin
          w_state_nxt = ST_BREAK;
          w_ferr      = 1'b1;
        end else if (w_decide && r_par_bad) begin
          w_state_nxt = ST_IDLE;
          w_perr      = 1'b1;
        end else if (w_decide) begin
          w_state_nxt = ST_IDLE;
          w_deliver   = 1'b1;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (w_rx) w_state_nxt = ST_IDLE;
        else      w_state_nxt = ST_BREAK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_deliver <= 1'b0;
      r_byte    <= 8'h00;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_ferr    <= w_ferr;
      r_perr    <= w_perr;
      r_deliver <= w_deliver;
      if (w_deliver) r_byte <= r_shift;
    end
  end

  // Holding register: a byte arriving while full and not being drained is dropped.
  always_ff @(posedge CLK_50_MAX10 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_deliver && (!r_valid || RX_READY)) begin
        r_data  <= r_byte;
        r_valid <= 1'b1;
      end else if (r_valid && RX_READY) begin
        r_valid <= 1'b0;
      end
      if (r_deliver && r_valid && !RX_READY) r_ovr <= 1'b1;
      else if (RX_ERR_CLR)                   r_ovr <= 1'b0;
    end
  end

  assign RX_DATA       = r_data;
  assign RX_VALID      = r_valid;
  assign RX_BUSY       = r_busy;
  assign RX_FRAME_ERR  = r_ferr;
  assign RX_PARITY_ERR = r_perr;
  assign RX_OVERRUN    = r_ovr;

endmodule

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
// Bench for uart_rx_deframer: directed scenarios plus randomized frames, checked against a
// frame-level model of the holding register and error counters.
module tb_uart_rx_deframer;
  localparam int CLK_HZ = 3_200_000;
  localparam int BAUD   = 100_000;
  localparam int OS     = 16;
  localparam int CPB    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_p, rx, rx_p, rdy, rdy_p, clr, clr_p;
  logic [7:0] data, data_p;
  logic       valid, valid_p, busy, busy_p, ferr, ferr_p, perr, perr_p, ovr, ovr_p;

  uart_rx_deframer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .PARITY(0)) dut (
    .CLK_50_MAX10(clk), .CPU_RESET(rst), .UART_RX(rx), .RX_DATA(data), .RX_VALID(valid),
    .RX_READY(rdy), .RX_BUSY(busy), .RX_FRAME_ERR(ferr), .RX_PARITY_ERR(perr),
    .RX_OVERRUN(ovr), .RX_ERR_CLR(clr));

  uart_rx_deframer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .PARITY(1)) dut_p (
    .CLK_50_MAX10(clk), .CPU_RESET(rst_p), .UART_RX(rx_p), .RX_DATA(data_p), .RX_VALID(valid_p),
    .RX_READY(rdy_p), .RX_BUSY(busy_p), .RX_FRAME_ERR(ferr_p), .RX_PARITY_ERR(perr_p),
    .RX_OVERRUN(ovr_p), .RX_ERR_CLR(clr_p));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_rise_cyc = -1000;
  logic valid_d = 1'b0;
  int n_ferr[2] = '{0, 0};
  int n_perr[2] = '{0, 0};
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  // Frame-level model state, index 0 = no-parity DUT, 1 = even-parity DUT
  logic       m_valid[2];
  logic [7:0] m_data[2];
  logic       m_ovr[2];
  int         e_ferr[2] = '{0, 0};
  int         e_perr[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && rdy) got_q.push_back({1'b0, data});
    if (valid_p && rdy_p) got_q.push_back({1'b1, data_p});
    n_ferr[0] <= n_ferr[0] + int'(ferr);
    n_ferr[1] <= n_ferr[1] + int'(ferr_p);
    n_perr[0] <= n_perr[0] + int'(perr);
    n_perr[1] <= n_perr[1] + int'(perr_p);
    valid_d <= valid;
    if (valid && !valid_d) last_rise_cyc <= cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx_p = b;
    else     rx = b;
  endtask

  task automatic set_ready(input bit sel, input logic level);
    if (sel) rdy_p = level;
    else     rdy = level;
    if (level && m_valid[sel]) begin
      exp_q.push_back({sel, m_data[sel]});
      m_valid[sel] = 1'b0;
    end
  endtask

  task automatic model_frame(input bit sel, input logic [7:0] d, input bit par_bad,
                             input bit stop_ok, input logic rdy_level);
    if (!stop_ok)                e_ferr[sel]++;
    else if (par_bad)            e_perr[sel]++;
    else if (rdy_level)          exp_q.push_back({sel, d});
    else if (m_valid[sel])       m_ovr[sel] = 1'b1;
    else begin
      m_valid[sel] = 1'b1;
      m_data[sel]  = d;
    end
  endtask

  // coincide: raise RX_READY for exactly the cycle the finished byte is loaded
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic sbit, input bit coincide);
    bit armed, release_r, seen;
    drive(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      tick(CPB);
    end
    if (has_par) begin
      drive(sel, pbit);
      tick(CPB);
    end
    drive(sel, sbit);
    stop_cyc = cyc;
    if (coincide) begin
      armed = 1'b1;
      release_r = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < CPB; k++) begin
        tick(1);
        if (release_r) begin
          rdy = 1'b0;
          release_r = 1'b0;
        end else if (armed && !busy) begin
          rdy = 1'b1;
          armed = 1'b0;
          release_r = 1'b1;
          seen = 1'b1;
        end
      end
      check_eq("coincide_window_found", 32'(seen), 32'd1);
    end else begin
      tick(CPB);
    end
  endtask

  task automatic check_state(input string tag, input bit sel);
    logic v, o;
    logic [7:0] dd;
    int n;
    v  = sel ? valid_p : valid;
    o  = sel ? ovr_p : ovr;
    dd = sel ? data_p : data;
    check_eq({tag, "_valid"}, 32'(v), 32'(m_valid[sel]));
    if (m_valid[sel]) check_eq({tag, "_data"}, 32'(dd), 32'(m_data[sel]));
    check_eq({tag, "_overrun"}, 32'(o), 32'(m_ovr[sel]));
    check_eq({tag, "_frame_err_cnt"}, n_ferr[sel], e_ferr[sel]);
    check_eq({tag, "_parity_err_cnt"}, n_perr[sel], e_perr[sel]);
    check_eq({tag, "_accepted_cnt"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_accepted_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       r, pbit;
    bit         sbad, pbad;
    int         delta;

    rx = 1'b1; rx_p = 1'b1; rdy = 1'b1; rdy_p = 1'b0; clr = 1'b0; clr_p = 1'b0;
    rst = 1'b1; rst_p = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = 1'b0; m_data[s] = 8'h00; m_ovr[s] = 1'b0;
    end
    tick(3);
    check_eq("reset_data", 32'(data), 32'h00);
    check_eq("reset_valid", 32'(valid), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_errs", 32'({ferr, perr, ovr, ferr_p, perr_p, ovr_p}), 32'd0);
    rst = 1'b0; rst_p = 1'b0;
    tick(5);

    // 1: clean 8N1 frame with consumer ready
    send_frame(0, 8'h55, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h55, 0, 1, 1'b1);
    delta = last_rise_cyc - (stop_cyc + 16);
    check_eq("t1_valid_within_19_of_midstop", 32'(delta >= 0 && delta <= 19), 32'd1);
    check_state("t1", 0);

    // 2: short low glitch is a false start
    rx = 1'b0;
    tick(8);
    check_eq("t2_busy_during_glitch", 32'(busy), 32'd1);
    rx = 1'b1;
    tick(64);
    check_eq("t2_busy_after", 32'(busy), 32'd0);
    check_state("t2", 0);

    // 3: bad stop bit followed by a held-low line
    send_frame(0, 8'hA5, 0, 1'b0, 1'b0, 0);
    model_frame(0, 8'hA5, 0, 0, 1'b1);
    tick(10 * CPB);
    check_eq("t3_busy_in_break", 32'(busy), 32'd1);
    tick(10 * CPB);
    check_state("t3_break", 0);
    rx = 1'b1;
    tick(CPB);
    check_eq("t3_busy_after_break", 32'(busy), 32'd0);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h3C, 0, 1, 1'b1);
    check_state("t3_next", 0);

    // 4: back-to-back frames with consumer stalled
    set_ready(0, 1'b0);
    send_frame(0, 8'h12, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h12, 0, 1, 1'b0);
    check_state("t4_first", 0);
    send_frame(0, 8'h34, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h34, 0, 1, 1'b0);
    check_state("t4_overrun", 0);
    set_ready(0, 1'b1);
    tick(1);
    set_ready(0, 1'b0);
    tick(2);
    check_state("t4_drained", 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_ovr[0] = 1'b0;
    tick(1);
    check_state("t4_cleared", 0);

    // 5: even parity, bad then good parity bit
    send_frame(1, 8'h07, 1, 1'b0, 1'b1, 0);
    model_frame(1, 8'h07, 1, 1, 1'b0);
    check_state("t5_bad_parity", 1);
    send_frame(1, 8'h07, 1, 1'b1, 1'b1, 0);
    model_frame(1, 8'h07, 0, 1, 1'b0);
    check_state("t5_good_parity", 1);

    // 6: reset in the middle of a frame, with the holding register full and overrun set
    send_frame(0, 8'h99, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h99, 0, 1, 1'b0);
    send_frame(0, 8'h66, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h66, 0, 1, 1'b0);
    check_state("t6_pre", 0);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + 16);
    check_eq("t6_busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(2);
    check_eq("t6_reset_data", 32'(data), 32'h00);
    check_eq("t6_reset_valid", 32'(valid), 32'd0);
    check_eq("t6_reset_busy", 32'(busy), 32'd0);
    check_eq("t6_reset_flags", 32'({ferr, perr, ovr}), 32'd0);
    m_valid[0] = 1'b0; m_data[0] = 8'h00; m_ovr[0] = 1'b0;
    rst = 1'b0;
    tick(16 + 4 * CPB);
    check_state("t6_after_reset", 0);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1, 0);
    model_frame(0, 8'h81, 0, 1, 1'b0);
    check_state("t6_81", 0);
    send_frame(0, 8'h42, 0, 1'b0, 1'b1, 1);
    exp_q.push_back({1'b0, 8'h81});
    m_data[0] = 8'h42;
    check_state("t6_coincide", 0);

    // randomized frames on the no-parity receiver
    for (int it = 0; it < 24; it++) begin
      d = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      sbad = ($urandom_range(0, 5) == 0);
      set_ready(0, r);
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_ovr[0] = 1'b0;
      end
      send_frame(0, d, 0, 1'b0, !sbad, 0);
      model_frame(0, d, 0, !sbad, r);
      if (sbad) begin
        tick(2 * CPB);
        rx = 1'b1;
        tick(CPB);
      end
      check_state("rand", 0);
      tick($urandom_range(0, 40));
    end

    // randomized frames on the parity receiver
    set_ready(1, 1'b1);
    for (int it = 0; it < 10; it++) begin
      d = 8'($urandom);
      pbad = ($urandom_range(0, 2) == 0);
      pbit = 1'(($countones(d) % 2) != 0) ^ 1'(pbad);
      send_frame(1, d, 1, pbit, 1'b1, 0);
      model_frame(1, d, pbad, 1, 1'b1);
      check_state("rand_par", 1);
      tick($urandom_range(0, 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
